// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, FSM state type and colour packing.
// Used by the driver and the receive-side decoder.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  localparam logic SYNC_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    SYNCED = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  function automatic logic [7:0] pack_color(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {r[7:5], g[7:5], b[7:6]};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers one sync/blank line twice and reports its asserted
// level plus one-cycle assert (on) and deassert (off) pulses.
module sync_edge_det #(
  parameter logic ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic level,
  output logic on,
  output logic off
);

  logic q;
  logic q2;

  // Input register plus history copy; resets to the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= ~ACTIVE;
      q2 <= ~ACTIVE;
    end else begin
      q  <= sig;
      q2 <= q;
    end
  end

  assign level = (q == ACTIVE);
  assign on    = level && (q2 != ACTIVE);
  assign off   = !level && (q2 == ACTIVE);

endmodule

// File: rtl/vga_rx_decoder.sv
// Receive-side VGA decoder: rebuilds pixel coordinates and colour,
// locks to frame timing, counts frames and checksums each frame.
module vga_rx_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int V_ACT = V_ACTIVE,
  parameter int H_TOT = H_TOTAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_n,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  pix_color,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [15:0] frame_sum,
  output logic        err_hlen,
  output logic        err_vlen
);

  logic hs_lvl, hs_edge, hs_off;
  logic vs_lvl, vs_edge, vs_off;
  logic blank_q, bl_on, bl_fall;
  logic [7:0] color_q;

  sync_edge_det #(.ACTIVE(SYNC_ACTIVE)) u_hs (
    .clk(clk), .rst_n(rst_n), .sig(hsync),
    .level(hs_lvl), .on(hs_edge), .off(hs_off)
  );

  sync_edge_det #(.ACTIVE(SYNC_ACTIVE)) u_vs (
    .clk(clk), .rst_n(rst_n), .sig(vsync),
    .level(vs_lvl), .on(vs_edge), .off(vs_off)
  );

  sync_edge_det #(.ACTIVE(1'b1)) u_bl (
    .clk(clk), .rst_n(rst_n), .sig(blank_n),
    .level(blank_q), .on(bl_on), .off(bl_fall)
  );

  logic unused_ok;
  assign unused_ok = ^{hs_lvl, hs_off, vs_lvl, vs_off, bl_on};

  rx_state_t   state;
  logic [9:0]  x_cnt;
  logic [9:0]  y_cnt;
  logic [11:0] h_per;
  logic        h_seen;
  logic        frame_ok;
  logic [15:0] acc;

  logic [9:0]  y_next;
  logic [15:0] acc_next;
  logic        hl_bad;
  logic        vl_bad;
  logic        err_now;
  logic        frame_good;

  // Colour is packed on the way in so only 8 bits are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) color_q <= '0;
    else        color_q <= pack_color(red, green, blue);
  end

  // Line/frame checks; a row ending this cycle counts before the frame check
  always_comb begin
    y_next = y_cnt;
    if (bl_fall && y_cnt != 10'h3ff) y_next = y_cnt + 10'd1;
    hl_bad = (bl_fall && x_cnt != 10'(H_ACT)) ||
             (hs_edge && h_seen && h_per != 12'(H_TOT));
    vl_bad = vs_edge && state != SEEK && y_next != 10'(V_ACT);
    err_now = hl_bad || vl_bad;
    frame_good = vs_edge && state != SEEK && frame_ok && !err_now;
    acc_next = acc + (pix_valid ? {8'h00, pix_color} : 16'h0000);
  end

  // Pixel decode, position counters, hsync period and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      h_per     <= '0;
      h_seen    <= 1'b0;
      err_hlen  <= 1'b0;
      err_vlen  <= 1'b0;
    end else begin
      pix_valid <= blank_q;
      if (blank_q) begin
        pix_x     <= x_cnt;
        pix_y     <= y_cnt;
        pix_color <= color_q;
      end
      unique case (1'b1)
        blank_q: if (x_cnt != 10'h3ff) x_cnt <= x_cnt + 10'd1;
        bl_fall: x_cnt <= '0;
        default: ;
      endcase
      y_cnt <= vs_edge ? 10'd0 : y_next;
      if (hs_edge)              h_per <= 12'd1;
      else if (h_per != 12'hfff) h_per <= h_per + 12'd1;
      h_seen   <= h_seen | hs_edge;
      err_hlen <= err_hlen | hl_bad;
      err_vlen <= err_vlen | vl_bad;
    end
  end

  // Lock FSM with registered lock flag, frame reporting and checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEEK;
      locked      <= 1'b0;
      frame_ok    <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      frame_sum   <= '0;
      acc         <= '0;
    end else begin
      unique case (state)
        SEEK: begin
          locked <= 1'b0;
          if (vs_edge) state <= SYNCED;
        end
        SYNCED: begin
          if (frame_good) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (err_now) begin
            state  <= SYNCED;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEEK;
          locked <= 1'b0;
        end
      endcase
      if (vs_edge)      frame_ok <= 1'b1;
      else if (err_now) frame_ok <= 1'b0;
      frame_done <= frame_good;
      if (frame_good) begin
        frame_sum   <= acc_next;
        frame_count <= frame_count + 16'd1;
      end
      acc <= vs_edge ? 16'h0000 : acc_next;
    end
  end

endmodule
